// File: rtl/hls_sobel_deadlock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hls_sobel_deadlock_pkg
//  Description : Shared types and report-word layout for the Sobel dataflow
//                deadlock reporter. The layout constants describe the default
//                configuration (7 processes, 4 AXI-Stream ports, 16-bit
//                timestamp). The report word is {timestamp, axis, proc}, with
//                the proc snapshot in the LSBs.
//  Revision    : 1.0 - initial release
// ============================================================================
package hls_sobel_deadlock_pkg;

    // Reporter state machine encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DETECTED = 2'd2,
        REPORTED = 2'd3
    } state_t;

    // Default field widths
    localparam int NUM_PROC_DEF = 7;
    localparam int NUM_AXIS_DEF = 4;
    localparam int CNT_W_DEF    = 16;

    // Report field offsets and total width
    localparam int PROC_LSB = 0;
    localparam int AXIS_LSB = NUM_PROC_DEF;
    localparam int TS_LSB   = NUM_PROC_DEF + NUM_AXIS_DEF;
    localparam int REPORT_W = CNT_W_DEF + NUM_AXIS_DEF + NUM_PROC_DEF;

endpackage
`default_nettype wire

// File: rtl/hls_sobel_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hls_sobel_sat_counter
//  Description : Saturating up-counter. Clear has priority over enable. When
//                the count is all-ones, it holds at that value.
//  Ports       : clock  - rising-edge clock
//                reset  - synchronous, active-high
//                clear  - synchronous clear to zero
//                enable - count up by one when not saturated
//                count  - current value
//  Revision    : 1.0 - initial release
// ============================================================================
module hls_sobel_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_max)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hls_sobel_deadlock_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : hls_sobel_deadlock_reporter
//  Description : Qualifies the dataflow deadlock monitor's block flag. The
//                flag must stay high for THRESHOLD consecutive cycles. The
//                block then captures process/port block snapshots and a cycle
//                timestamp. The capture is offered as one report word on a
//                valid/ready handshake. The deadlock indication is sticky
//                until clear or reset.
//  Ports       : clock, reset        - clock, synchronous active-high reset
//                block_in            - deadlock monitor block flag
//                inst_block_sigs     - per-process channel-block flags
//                axis_block_sigs     - per-port AXI-Stream block flags
//                clear               - return to IDLE, drop pending report
//                deadlock            - sticky deadlock indication
//                deadlock_pulse      - one-cycle strobe on declaration
//                report_valid/ready  - report handshake
//                report_data         - {timestamp, axis snapshot, proc snapshot}
//  Revision    : 1.0 - initial release
// ============================================================================
module hls_sobel_deadlock_reporter
    import hls_sobel_deadlock_pkg::*;
#(
    parameter int NUM_PROC  = NUM_PROC_DEF,
    parameter int NUM_AXIS  = NUM_AXIS_DEF,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               block_in,
    input  logic [NUM_PROC-1:0]                inst_block_sigs,
    input  logic [NUM_AXIS-1:0]                axis_block_sigs,
    input  logic                               clear,
    output logic                               deadlock,
    output logic                               deadlock_pulse,
    output logic                               report_valid,
    input  logic                               report_ready,
    output logic [CNT_W+NUM_AXIS+NUM_PROC-1:0] report_data
);

    localparam int               c_rep_w    = CNT_W + NUM_AXIS + NUM_PROC;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(THRESHOLD - 1);
    localparam bit               c_one_shot = (THRESHOLD == 1);

    state_t             r_state;
    logic               r_deadlock;
    logic               r_pulse;
    logic               r_valid;
    logic [c_rep_w-1:0] r_data;

    logic [CNT_W-1:0]   w_cycle_cnt;
    logic [CNT_W-1:0]   w_consec_cnt;
    logic               w_qualifying;
    logic               w_capture;
    logic               w_cnt_en;
    logic               w_cnt_clear;

    // Free-running timestamp. It is never cleared by clear, and it saturates.
    hls_sobel_sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (1'b0),
        .enable (1'b1),
        .count  (w_cycle_cnt)
    );

    // Consecutive-high counter. It only counts while qualifying. It is
    // cleared on any low cycle and on declaration, so it stays below THRESHOLD.
    hls_sobel_sat_counter #(
        .WIDTH (CNT_W)
    ) u_consec_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_cnt_clear),
        .enable (w_cnt_en),
        .count  (w_consec_cnt)
    );

    assign w_qualifying = (r_state == IDLE) || (r_state == ARMED);

    // A capture happens on the cycle that completes the qualifying run.
    // Clear suppresses it.
    always_comb begin
        w_capture = 1'b0;
        if (!clear && block_in) begin
            case (r_state)
                IDLE:    w_capture = c_one_shot;
                ARMED:   w_capture = (w_consec_cnt == c_last_cnt);
                default: w_capture = 1'b0;
            endcase
        end
    end

    assign w_cnt_en    = block_in && w_qualifying;
    assign w_cnt_clear = clear || !block_in || !w_qualifying || w_capture;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_deadlock <= 1'b0;
            r_pulse    <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_pulse <= 1'b0;
            if (clear) begin
                // A simultaneous valid&ready is still seen as a transfer by
                // the consumer. The report is simply not re-offered.
                r_state    <= IDLE;
                r_deadlock <= 1'b0;
                r_valid    <= 1'b0;
            end else if (w_capture) begin
                r_state    <= DETECTED;
                r_deadlock <= 1'b1;
                r_pulse    <= 1'b1;
                r_valid    <= 1'b1;
                r_data     <= {w_cycle_cnt, axis_block_sigs, inst_block_sigs};
            end else begin
                case (r_state)
                    IDLE: begin
                        if (block_in) begin
                            r_state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (!block_in) begin
                            r_state <= IDLE;
                        end
                    end
                    DETECTED: begin
                        if (r_valid && report_ready) begin
                            r_state <= REPORTED;
                            r_valid <= 1'b0;
                        end
                    end
                    REPORTED: begin
                        // Sticky: only clear or reset leaves this state
                        r_state <= REPORTED;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign deadlock       = r_deadlock;
    assign deadlock_pulse = r_pulse;
    assign report_valid   = r_valid;
    assign report_data    = r_data;

endmodule
`default_nettype wire

// File: doc/hls_sobel_deadlock_reporter.md
# hls_sobel_deadlock_reporter

Consumes the registered `block` flag of the top-level dataflow deadlock monitor and turns it into a qualified, sticky deadlock report. A deadlock is declared only after the flag stays high for `THRESHOLD` consecutive cycles. On declaration the block captures which processes were channel-blocked, which AXI-Stream ports were blocked, and a cycle timestamp. The capture is offered as one report word on a valid/ready handshake to the debug/status logic of the Sobel AXI-Stream top.

## Interface
- `NUM_PROC`, 7: number of dataflow processes (width of the channel-block snapshot).
- `NUM_AXIS`, 4: number of AXI-Stream block signals.
- `THRESHOLD`, 16: consecutive high cycles of `block_in` required; legal range 1..2^`CNT_W`-1.
- `CNT_W`, 16: width of the consecutive counter and of the timestamp.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `block_in`, in, 1: deadlock-monitor `block` output.
- `inst_block_sigs`, in, `NUM_PROC`: per-process channel-block flags, sampled at capture.
- `axis_block_sigs`, in, `NUM_AXIS`: per-port AXI-Stream block flags, sampled at capture.
- `clear`, in, 1: returns the block to IDLE and discards any pending report.
- `deadlock`, out, 1: sticky deadlock indication.
- `deadlock_pulse`, out, 1: one-cycle strobe marking the first cycle of declaration.
- `report_valid`, out, 1: report word available.
- `report_ready`, in, 1: consumer accepts the report word.
- `report_data`, out, `CNT_W`+`NUM_AXIS`+`NUM_PROC`: report word, packed as {timestamp, axis snapshot, proc snapshot}; proc snapshot in the LSBs.

## Operation
FSM states:
- IDLE
  - `block_in`=1 -> ARMED, with cnt=1.
  - If `THRESHOLD`=1, go directly to DETECTED with capture instead.
- ARMED
  - `block_in`=0 -> IDLE, cnt=0.
  - `block_in`=1 and cnt=`THRESHOLD`-1 -> DETECTED with capture.
  - `block_in`=1 otherwise -> stay, cnt+1.
- DETECTED
  - `report_valid`=1 and `deadlock`=1.
  - `report_valid`&`report_ready` -> REPORTED.
- REPORTED
  - `deadlock`=1, `report_valid`=0.
  - `block_in` is ignored; only `clear` exits (-> IDLE).

Capture (at the transition edge into DETECTED):
- proc snapshot <= `inst_block_sigs`.
- axis snapshot <= `axis_block_sigs`.
- timestamp <= current free-running cycle counter.
- `report_data` is held stable while `report_valid`=1.

Counters:
- Free-running cycle counter: reset to 0, +1 every cycle, saturates at all-ones and does not wrap.
- Consecutive counter: `CNT_W` bits; it never exceeds `THRESHOLD`-1.

`clear`:
- Allowed in every state; takes the block to IDLE, with cnt=0, `deadlock`=0, `report_valid`=0.
- Clear beats a simultaneous capture or handshake.
- A simultaneous valid&ready is still treated as transferred by the consumer.
- Does not reset the cycle counter.

## Timing
- Reset values:
  - `deadlock`=0, `deadlock_pulse`=0, `report_valid`=0, `report_data`=0.
  - State IDLE, both counters 0.
- `block_in` high on sampled cycles k..k+`THRESHOLD`-1 -> in cycle k+`THRESHOLD`: `report_valid`=`deadlock`=`deadlock_pulse`=1.
- `deadlock_pulse` is high exactly one cycle per declaration.
- A single low cycle of `block_in` in ARMED restarts qualification from zero.
- Handshake:
  - The transfer occurs on an edge with valid&ready both high.
  - `report_valid` deasserts the next cycle.
  - `report_valid` never deasserts without a transfer, except on `clear` or `reset`.
  - `report_ready` may be high before valid; it has no combinational path to any output.
- All outputs are registered.
- Reset asserted mid-report: the next cycle matches the reset values; the pending report is lost.

## Structure
- Package `hls_sobel_deadlock_pkg` holds:
  - the state enum (IDLE, ARMED, DETECTED, REPORTED);
  - localparams for report-field widths and offsets (PROC_LSB=0, AXIS_LSB=`NUM_PROC`, TS_LSB=`NUM_PROC`+`NUM_AXIS`);
  - the report word width.
- Sub-module `hls_sobel_sat_counter`: a parameterised saturating up-counter with sync clear and enable. It is instantiated twice, for the cycle counter and the consecutive counter.

## Test plan
- `THRESHOLD`=16, `block_in` high 15 cycles then low -> no `report_valid`, no pulse; state back to IDLE; a following 16-cycle run declares normally.
- Reset released at cycle 0, `block_in` high from cycle 100, `inst_block_sigs`=7'h25, `axis_block_sigs`=4'h8 -> `report_valid` at cycle 116 with `report_data`={16'd115, 4'h8, 7'h25}; pulse for one cycle only.
- `report_ready` low for 5 cycles after valid -> `report_data` stable throughout, valid held; ready high -> valid drops next cycle, `deadlock` stays 1.
- In REPORTED, toggle `block_in` for 100 cycles -> no new report; `clear` -> `deadlock`=0; a new 16-cycle run produces a second report.
- `clear` in the same cycle as the capture edge, and again together with valid&ready -> state IDLE, `deadlock`=0, no pulse on the first.
- `THRESHOLD`=1, and separately the cycle counter forced near saturation -> declaration one cycle after the first high `block_in`; timestamp saturates at 16'hFFFF without wrapping.
